muldiv_unit: RTL and testbench

- Iterative RV64M multiply/divide unit in the execute stage.
- Consumes the same operand pair the ALU gets: rs1 value, and the selected second operand from the operand-2 mux.
- Holds the instruction in execute via busy until the result is ready, then hands the 64-bit result to the execute/memory pipeline register with a valid/ready handshake.
- Radix-2: one quotient or partial-product bit per cycle.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_fixup.sv | 58 +++++
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types, constants and op-classification helpers for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int XLEN   = 64;
   localparam int ITER_D = 64;  // iterations for doubleword ops
   localparam int ITER_W = 32;  // iterations for word (W) ops
   localparam int CNT_W  = 7;   // wide enough to hold ITER_D

   typedef enum logic [3:0] {
      MUL, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW
   } mul_div_op_t;

   typedef enum logic [1:0] {
      IDLE, BUSY, DONE
   } mul_div_state_t;

   function automatic logic op_is_w(input mul_div_op_t o);
      return o inside {MULW, DIVW, DIVUW, REMW, REMUW};
   endfunction

   // Every op except the two multiplies runs through the divider.
   function automatic logic op_is_div(input mul_div_op_t o);
      return !(o inside {MUL, MULW});
   endfunction

   function automatic logic op_is_rem(input mul_div_op_t o);
      return o inside {REM, REMU, REMW, REMUW};
   endfunction

   function automatic logic op_is_signed(input mul_div_op_t o);
      return o inside {DIV, REM, DIVW, REMW};
   endfunction

   // W results are always the sign-extended low word, even for unsigned ops.
   function automatic logic [XLEN-1:0] wsext(input logic is_w, input logic [XLEN-1:0] v);
      return is_w ? {{32{v[31]}}, v[31:0]} : v;
   endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// Combinational operand conditioning (W truncation, magnitudes, sign, special cases)
// and final result fix-up (negation, W sign-extension).
module muldiv_fixup
   import muldiv_pkg::*;
(
   input  mul_div_op_t      op,
   input  logic [XLEN-1:0]  src1,
   input  logic [XLEN-1:0]  src2,
   output logic [XLEN-1:0]  mag_a,
   output logic [XLEN-1:0]  mag_b,
   output logic             neg_res,
   output logic             special,
   output logic [XLEN-1:0]  special_result,
   input  mul_div_op_t      op_lat,
   input  logic             neg_lat,
   input  logic [XLEN-1:0]  raw,
   output logic [XLEN-1:0]  final_result
);

   logic            sgn;
   logic            w;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [XLEN-1:0] sp_raw;

   // Extend/truncate operands, take magnitudes and detect divide-by-zero / overflow.
   always_comb begin
      sgn = op_is_signed(op);
      w   = op_is_w(op);
      a   = src1;
      b   = src2;
      if (w) begin
         a = sgn ? {{32{src1[31]}}, src1[31:0]} : {32'b0, src1[31:0]};
         b = sgn ? {{32{src2[31]}}, src2[31:0]} : {32'b0, src2[31:0]};
      end
      mag_a   = (sgn && a[XLEN-1]) ? -a : a;
      mag_b   = (sgn && b[XLEN-1]) ? -b : b;
      // Remainder follows the dividend sign; quotient negates when signs differ.
      neg_res = sgn && (op_is_rem(op) ? a[XLEN-1] : (a[XLEN-1] ^ b[XLEN-1]));
      div_zero = op_is_div(op) && (b == '0);
      ovf = sgn && (b == '1) &&
            (a == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
      special = div_zero || ovf;
      if (op_is_rem(op))
         sp_raw = div_zero ? a : '0;
      else
         sp_raw = div_zero ? '1 : a;
      special_result = wsext(w, sp_raw);
   end

   // Apply the recorded sign and W sign-extension to the unsigned iteration result.
   always_comb begin
      final_result = wsext(op_is_w(op_lat), neg_lat ? -raw : raw);
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV64M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with valid/ready hand-off of the 64-bit result.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  mul_div_op_t      op,
   input  logic [XLEN-1:0]  src1,
   input  logic [XLEN-1:0]  src2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic             busy
);

   mul_div_state_t   state, state_next;
   mul_div_op_t      op_reg;
   logic             neg_reg;
   logic [CNT_W-1:0] cnt;
   // acc: product accumulator / partial remainder
   // opa: multiplier (shifts right) / dividend-then-quotient (shifts left)
   // opb: multiplicand (shifts left) / divisor
   logic [XLEN-1:0]  acc, opa, opb;
   logic [XLEN-1:0]  acc_step, opa_step, opb_step;
   logic [XLEN:0]    shifted, diff;
   logic [XLEN-1:0]  raw;
   logic [XLEN-1:0]  result_reg;

   logic [XLEN-1:0]  mag_a, mag_b, special_result, final_result;
   logic             neg_res, special;

   muldiv_fixup u_fixup (
      .op             (op),
      .src1           (src1),
      .src2           (src2),
      .mag_a          (mag_a),
      .mag_b          (mag_b),
      .neg_res        (neg_res),
      .special        (special),
      .special_result (special_result),
      .op_lat         (op_reg),
      .neg_lat        (neg_reg),
      .raw            (raw),
      .final_result   (final_result)
   );

   // One iteration step of the active algorithm, plus the unsigned result it would produce.
   always_comb begin
      shifted  = {acc, opa[XLEN-1]};
      diff     = shifted - {1'b0, opb};
      acc_step = acc;
      opa_step = opa;
      opb_step = opb;
      if (op_is_div(op_reg)) begin
         acc_step = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
         opa_step = {opa[XLEN-2:0], ~diff[XLEN]};
      end else begin
         acc_step = opa[0] ? acc + opb : acc;
         opb_step = opb << 1;
         opa_step = opa >> 1;
      end
      if (!op_is_div(op_reg) || op_is_rem(op_reg))
         raw = acc_step;
      else
         raw = opa_step;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic; flush overrides everything.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = special ? DONE : BUSY;
         BUSY:    if (cnt == CNT_W'(1)) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   // Operand latch on accept, iteration on each BUSY edge, result load on the last step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_reg     <= MUL;
         neg_reg    <= 1'b0;
         cnt        <= '0;
         acc        <= '0;
         opa        <= '0;
         opb        <= '0;
         result_reg <= '0;
      end else if (!flush) begin
         if (state == IDLE && in_valid) begin
            op_reg  <= op;
            neg_reg <= neg_res;
            acc     <= '0;
            if (special) begin
               cnt        <= '0;
               result_reg <= special_result;
            end else begin
               cnt <= op_is_w(op) ? CNT_W'(ITER_W) : CNT_W'(ITER_D);
            end
            if (op_is_div(op)) begin
               // W dividends sit in the upper word so 32 shifts consume them.
               opa <= op_is_w(op) ? {mag_a[31:0], 32'b0} : mag_a;
               opb <= mag_b;
            end else begin
               opa <= mag_b;
               opb <= mag_a;
            end
         end else if (state == BUSY) begin
            acc <= acc_step;
            opa <= opa_step;
            opb <= opb_step;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) result_reg <= final_result;
         end
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == BUSY) || (state == DONE && !out_ready);
   assign result    = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expectations, a monitor
// checks result and first-valid latency of every delivered result.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   mul_div_op_t      op = MUL;
   logic [63:0]      src1 = '0;
   logic [63:0]      src2 = '0;
   logic             flush = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [63:0]      result;
   logic             busy;

   int checks = 0;
   int errors = 0;
   int cycle_cnt = 0;

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          issued;
      string       name;
   } exp_t;

   exp_t sb[$];
   logic seen = 1'b0;

   muldiv_unit dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   // Drive stimulus away from the sampling edges.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input string name, input mul_div_op_t o, input logic [63:0] a,
                        input logic [63:0] b, input logic expect_it,
                        input logic [63:0] exp_res, input int exp_lat);
      int g;
      exp_t e;
      g = 0;
      while (!in_ready && g < 300) begin
         step();
         g++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL %s_accept_timeout: in_ready=%0b required 1", name, in_ready);
      end
      if (expect_it) begin
         e.res = exp_res;
         e.lat = exp_lat;
         e.issued = cycle_cnt;
         e.name = name;
         sb.push_back(e);
      end
      op = o;
      src1 = a;
      src2 = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 300) begin
         step();
         g++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   // Monitor: latency on first out_valid, result on handshake.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: result 0x%h with no outstanding op", result);
         end else begin
            if (!seen) begin
               seen = 1'b1;
               check({sb[0].name, "_latency"}, 64'(cycle_cnt - sb[0].issued), 64'(sb[0].lat));
            end
            if (out_ready) begin
               check({sb[0].name, "_result"}, result, sb[0].res);
               $display("txn %s result=0x%h cycles=%0d", sb[0].name, result,
                        cycle_cnt - sb[0].issued);
               void'(sb.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step();
      step();
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_result", result, 64'd0);
      reset = 1'b0;
      step();

      // Signed divide with mixed signs
      issue("div_m7_2", DIV, -64'sd7, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      issue("rem_m7_2", REM, -64'sd7, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      // Divide by zero
      issue("divu_by0", DIVU, 64'h1234, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      issue("remu_by0", REMU, 64'h1234, 64'd0, 1'b1, 64'h1234, 1);
      issue("divw_by0", DIVW, 64'd5, 64'h1_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      // Signed overflow
      issue("div_ovf", DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
            64'h8000_0000_0000_0000, 1);
      issue("rem_ovf", REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1);
      issue("divw_ovf", DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
      // Multiplies
      issue("mulw", MULW, 64'h7FFF_FFFF, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
      issue("mul", MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      // Word divides
      issue("divuw", DIVUW, 64'hFFFF_FFFF, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
      issue("remw", REMW, 64'hFFFF_FFF9, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
      issue("remuw", REMUW, 64'd100, 64'd7, 1'b1, 64'd2, 33);
      drain();

      // Back-pressure in DONE
      out_ready = 1'b0;
      issue("mul_hold", MUL, 64'd6, 64'd7, 1'b1, 64'd42, 65);
      begin
         int g;
         g = 0;
         while (!out_valid && g < 200) begin
            step();
            g++;
         end
      end
      for (int i = 0; i < 5; i++) begin
         check("hold_result", result, 64'd42);
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_busy", 64'(busy), 64'd1);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         op = DIVU;
         src1 = 64'd1;
         src2 = 64'd1;
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      check("release_in_ready", 64'(in_ready), 64'd1);
      drain();

      // Flush mid-iteration with in_valid also high
      issue("div_flushed", DIV, 64'd1000, 64'd3, 1'b0, 64'd0, 0);
      repeat (9) step();
      flush = 1'b1;
      in_valid = 1'b1;
      op = DIVU;
      src1 = 64'd9;
      src2 = 64'd3;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_in_ready", 64'(in_ready), 64'd1);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_busy", 64'(busy), 64'd0);
      repeat (80) step();

      // Asynchronous reset mid-BUSY
      issue("divu_reset", DIVU, 64'd100, 64'd7, 1'b0, 64'd0, 0);
      repeat (5) step();
      #1;
      reset = 1'b1;
      #1;
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_result", result, 64'd0);
      step();
      reset = 1'b0;
      step();

      issue("divu_100_7", DIVU, 64'd100, 64'd7, 1'b1, 64'd14, 65);
      issue("remu_100_7", REMU, 64'd100, 64'd7, 1'b1, 64'd2, 65);
      drain();
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
